// File: rtl/pixel_write_back_if.sv
// Fragment input, frame-done handshake and Avalon-MM write master signals
// for the rasterizer write-back stage.
interface pixel_write_back_if #(
    parameter int ADDR_W = 26
);
    logic              input_valid;
    logic [ADDR_W-1:0] addr_in;
    logic [23:0]       color_in;
    logic [31:0]       depth_in;
    logic              done_in;
    logic              stall_out;
    logic              done_out;
    logic              overflow;
    logic [ADDR_W-1:0] master_address;
    logic              master_read;
    logic              master_write;
    logic [3:0]        master_byteenable;
    logic [31:0]       master_writedata;
    logic              master_waitrequest;

    // Write-back block side: consumes fragments, drives the SDRAM bus.
    modport master (
        input  input_valid, addr_in, color_in, depth_in, done_in,
        input  master_waitrequest,
        output stall_out, done_out, overflow,
        output master_address, master_read, master_write,
        output master_byteenable, master_writedata
    );

    // Environment side: ztest plus the SDRAM slave.
    modport slave (
        output input_valid, addr_in, color_in, depth_in, done_in,
        output master_waitrequest,
        input  stall_out, done_out, overflow,
        input  master_address, master_read, master_write,
        input  master_byteenable, master_writedata
    );
endinterface

// File: rtl/pixel_write_back.sv
// Rasterizer write-back: buffers z-passed fragments and retires each one as
// a colour write followed by a depth write on an Avalon-MM master.
//
// state    | meaning
// IDLE     | bus quiet, waiting for a buffered fragment
// WR_COLOR | colour word being written (first cycle loads the bus from hold)
// WR_DEPTH | depth word being written at colour address + DEPTH_OFFSET
module pixel_write_back #(
    parameter int                ADDR_W       = 26,
    parameter int                FIFO_DEPTH   = 8,
    parameter int                STALL_MARGIN = 2,
    parameter logic [ADDR_W-1:0] DEPTH_OFFSET = 'h0100000
) (
    input logic               clock,
    input logic               reset,
    pixel_write_back_if.master bus
);
    localparam int HA_W    = ADDR_W - 2;
    localparam int ENTRY_W = HA_W + 24 + 32;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(FIFO_DEPTH - STALL_MARGIN);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WR_COLOR = 2'd1;
    localparam logic [1:0] WR_DEPTH = 2'd2;

    logic [1:0]         state;
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_next;
    logic               full, empty, push, pop, bus_ack, done_fire;
    logic [ENTRY_W-1:0] head;
    logic [HA_W-1:0]    head_addr, hold_addr;
    logic [23:0]        head_color, hold_color;
    logic [31:0]        head_depth, hold_depth;
    logic [ADDR_W-1:0]  depth_addr;
    logic               done_pending;
    logic               stall_q, done_q, overflow_q, write_q;
    logic [ADDR_W-1:0]  address_q;
    logic [31:0]        writedata_q;
    logic [3:0]         byteenable_q;

    assign bus.stall_out         = stall_q;
    assign bus.done_out          = done_q;
    assign bus.overflow          = overflow_q;
    assign bus.master_read       = 1'b0;
    assign bus.master_write      = write_q;
    assign bus.master_address    = address_q;
    assign bus.master_writedata  = writedata_q;
    assign bus.master_byteenable = byteenable_q;

    // FIFO flags, pop decision and next occupancy.
    always_comb begin
        full       = (count == FULL_CNT);
        empty      = (count == '0);
        push       = bus.input_valid && !full;
        bus_ack    = write_q && !bus.master_waitrequest;
        pop        = !empty && ((state == IDLE) || (state == WR_DEPTH && bus_ack));
        head       = mem[rd_ptr];
        head_addr  = head[ENTRY_W-1 -: HA_W];
        head_color = head[55:32];
        head_depth = head[31:0];
        depth_addr = {hold_addr, 2'b00} + DEPTH_OFFSET;
        done_fire  = done_pending && empty && (state == IDLE);
        count_next = count;
        if (push && !pop)
            count_next = count + CNT_W'(1);
        else if (!push && pop)
            count_next = count - CNT_W'(1);
    end

    // Fragment storage; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= {bus.addr_in[ADDR_W-1:2], bus.color_in, bus.depth_in};
    end

    // FIFO pointers, occupancy, registered stall and sticky overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count      <= count_next;
            stall_q    <= (count_next >= STALL_AT);
            overflow_q <= overflow_q | (bus.input_valid && full);
        end
    end

    // End-of-frame tracking; a done arriving with the firing cycle merges into it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_pending <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_pending <= (done_pending | bus.done_in) & ~done_fire;
            done_q       <= done_fire;
        end
    end

    // Write sequencer; back-to-back fragments load the bus straight from the FIFO head.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            hold_addr    <= '0;
            hold_color   <= '0;
            hold_depth   <= '0;
            write_q      <= 1'b0;
            address_q    <= '0;
            writedata_q  <= '0;
            byteenable_q <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        hold_addr  <= head_addr;
                        hold_color <= head_color;
                        hold_depth <= head_depth;
                        state      <= WR_COLOR;
                    end
                end
                WR_COLOR: begin
                    if (!write_q) begin
                        write_q      <= 1'b1;
                        byteenable_q <= 4'b1111;
                        address_q    <= {hold_addr, 2'b00};
                        writedata_q  <= {8'h00, hold_color};
                    end else if (!bus.master_waitrequest) begin
                        address_q   <= depth_addr;
                        writedata_q <= hold_depth;
                        state       <= WR_DEPTH;
                    end
                end
                WR_DEPTH: begin
                    if (!bus.master_waitrequest) begin
                        if (!empty) begin
                            hold_addr   <= head_addr;
                            hold_color  <= head_color;
                            hold_depth  <= head_depth;
                            address_q   <= {head_addr, 2'b00};
                            writedata_q <= {8'h00, head_color};
                            state       <= WR_COLOR;
                        end else begin
                            write_q      <= 1'b0;
                            byteenable_q <= 4'b0000;
                            state        <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_write_back.sv
// Scoreboard bench for pixel_write_back: stimulus pushes the expected colour
// and depth writes into a queue, a negedge monitor pops and compares them.
module tb_pixel_write_back;
    localparam int          ADDR_W       = 26;
    localparam int          FIFO_DEPTH   = 8;
    localparam int          STALL_MARGIN = 2;
    localparam logic [25:0] DEPTH_OFFSET = 26'h0100000;

    typedef struct {
        logic [25:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pixel_write_back_if #(.ADDR_W(ADDR_W)) bus ();

    pixel_write_back #(
        .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH),
        .STALL_MARGIN(STALL_MARGIN), .DEPTH_OFFSET(DEPTH_OFFSET)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.master)
    );

    wr_t exp_q[$];
    int compared = 0, mismatched = 0;
    int wr_count = 0, done_pulses = 0, done_at = 0;
    logic        have_prev = 1'b0;
    logic [25:0] prev_addr;
    logic [31:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: a fragment becomes a colour write then a depth write.
    task automatic model_issue(input logic [25:0] a, input logic [23:0] c, input logic [31:0] d);
        logic [25:0] base;
        logic [25:0] daddr;
        base  = {a[25:2], 2'b00};
        daddr = base + DEPTH_OFFSET;
        exp_q.push_back('{addr: base, data: {8'h00, c}});
        exp_q.push_back('{addr: daddr, data: d});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_frag(input logic [25:0] a, input logic [23:0] c, input logic [31:0] d,
                              input logic accept);
        bus.input_valid = 1'b1;
        bus.addr_in     = a;
        bus.color_in    = c;
        bus.depth_in    = d;
        if (accept) model_issue(a, c, d);
        tick();
        bus.input_valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        tick();
        tick();
    endtask

    // Monitor: every accepted write is popped and compared; stalled writes must hold.
    always @(negedge clock) begin
        if (reset) begin
            if (bus.master_read) check("master_read", 64'(bus.master_read), 64'd0);
            if (bus.master_write) begin
                if (bus.master_byteenable != 4'hF)
                    check("byteenable", 64'(bus.master_byteenable), 64'hF);
                if (have_prev) begin
                    check("hold_addr", 64'(bus.master_address), 64'(prev_addr));
                    check("hold_data", 64'(bus.master_writedata), 64'(prev_data));
                end
                if (!bus.master_waitrequest) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 64'(bus.master_address), 64'h0);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check("wr_addr", 64'(bus.master_address), 64'(e.addr));
                        check("wr_data", 64'(bus.master_writedata), 64'(e.data));
                    end
                    wr_count++;
                    have_prev = 1'b0;
                end else begin
                    have_prev = 1'b1;
                    prev_addr = bus.master_address;
                    prev_data = bus.master_writedata;
                end
            end else begin
                have_prev = 1'b0;
            end
            if (bus.done_out) begin
                done_pulses++;
                done_at = wr_count;
            end
        end
    end

    initial begin
        int base, pulses0, issued, n, occ;
        logic [25:0] ra;
        logic [25:0] daddr;
        bus.input_valid        = 1'b0;
        bus.addr_in            = '0;
        bus.color_in           = '0;
        bus.depth_in           = '0;
        bus.done_in            = 1'b0;
        bus.master_waitrequest = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        check("rst_write", 64'(bus.master_write), 64'd0);
        check("rst_stall", 64'(bus.stall_out), 64'd0);
        check("rst_done", 64'(bus.done_out), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        check("rst_byteenable", 64'(bus.master_byteenable), 64'd0);
        check("rst_address", 64'(bus.master_address), 64'd0);

        // Single fragment and first-write latency.
        base = wr_count;
        drive_frag(26'h0000104, 24'hABCDEF, 32'h3F000000, 1'b1);
        check("lat_edge_n", 64'(bus.master_write), 64'd0);
        tick();
        check("lat_edge_n1", 64'(bus.master_write), 64'd0);
        tick();
        check("lat_edge_n2", 64'(bus.master_write), 64'd1);
        drain(20);
        check("single_writes", 64'(wr_count - base), 64'd2);

        // Waitrequest held during the colour write.
        bus.master_waitrequest = 1'b1;
        ra = 26'h0A5A5A8;
        drive_frag(ra, 24'h123456, 32'hDEADBEEF, 1'b1);
        n = 0;
        while (!bus.master_write && n < 10) begin
            tick();
            n++;
        end
        check("wait_color_start", 64'(bus.master_write), 64'd1);
        repeat (5) tick();
        check("wait_still_writing", 64'(bus.master_write), 64'd1);
        bus.master_waitrequest = 1'b0;
        tick();
        daddr = {ra[25:2], 2'b00} + DEPTH_OFFSET;
        check("depth_start_write", 64'(bus.master_write), 64'd1);
        check("depth_start_addr", 64'(bus.master_address), 64'(daddr));
        drain(20);

        // Depth address wraps past the top of the address space.
        drive_frag(26'h3FFFF00, 24'h00FF00, 32'h00000001, 1'b1);
        drain(20);

        // done_in with the third fragment: one pulse, only after all six writes.
        base    = wr_count;
        pulses0 = done_pulses;
        drive_frag(26'h0000200, 24'h000001, 32'h11111111, 1'b1);
        drive_frag(26'h0000204, 24'h000002, 32'h22222222, 1'b1);
        bus.done_in = 1'b1;
        drive_frag(26'h0000208, 24'h000003, 32'h33333333, 1'b1);
        bus.done_in = 1'b0;
        drain(40);
        repeat (5) tick();
        check("done_pulses", 64'(done_pulses - pulses0), 64'd1);
        check("done_after_writes", 64'(done_at - base), 64'd6);

        // Randomized traffic with random waitrequest, honouring stall_out.
        issued = 0;
        for (int i = 0; i < 600 && issued < 60; i++) begin
            bus.master_waitrequest = ($urandom_range(0, 3) == 0);
            if (!bus.stall_out && $urandom_range(0, 2) != 0) begin
                drive_frag(26'($urandom), 24'($urandom), $urandom, 1'b1);
                issued++;
            end else begin
                tick();
            end
        end
        bus.master_waitrequest = 1'b0;
        drain(400);
        check("rand_issued", 64'(issued), 64'd60);
        check("rand_no_overflow", 64'(bus.overflow), 64'd0);

        // Back-pressure: one fragment moves to the hold registers, the FIFO
        // absorbs FIFO_DEPTH more, and the next one is dropped.
        bus.master_waitrequest = 1'b1;
        base = wr_count;
        for (int k = 1; k <= FIFO_DEPTH + 2; k++) begin
            drive_frag(26'(32'h0010000 + k * 16), 24'(k * 3), 32'(k * 7), k <= FIFO_DEPTH + 1);
            occ = (k == 1) ? 1 : ((k - 1 > FIFO_DEPTH) ? FIFO_DEPTH : k - 1);
            check("bp_stall", 64'(bus.stall_out), 64'((FIFO_DEPTH - occ) <= STALL_MARGIN));
            check("bp_overflow", 64'(bus.overflow), 64'(k > FIFO_DEPTH + 1));
        end
        bus.master_waitrequest = 1'b0;
        drain(100);
        check("bp_write_count", 64'(wr_count - base), 64'(2 * (FIFO_DEPTH + 1)));
        check("bp_stall_released", 64'(bus.stall_out), 64'd0);

        // Reset asserted while the depth write is stalled and three fragments wait.
        bus.master_waitrequest = 1'b1;
        for (int k = 0; k < 4; k++)
            drive_frag(26'(32'h0200000 + k * 4), 24'(k + 1), 32'(k + 100), 1'b1);
        bus.master_waitrequest = 1'b0;
        tick();
        bus.master_waitrequest = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        check("rst_mid_write", 64'(bus.master_write), 64'd0);
        check("rst_mid_stall", 64'(bus.stall_out), 64'd0);
        check("rst_mid_overflow", 64'(bus.overflow), 64'd0);
        exp_q.delete();
        base = wr_count;
        tick();
        tick();
        reset = 1'b1;
        bus.master_waitrequest = 1'b0;
        repeat (20) tick();
        check("rst_no_writes", 64'(wr_count - base), 64'd0);
        check("rst_idle_write", 64'(bus.master_write), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
